// File: rtl/max10nios_pio_pkg.sv
// Shared definitions for the multi-bit Avalon-MM output PIO:
// register word offsets, STATUS bit positions and the pulse FSM state type.
package max10nios_pio_pkg;

   // Register word offsets within the s1 slave
   localparam logic [2:0] ADDR_DATA       = 3'd0;
   localparam logic [2:0] ADDR_PULSE_LEN  = 3'd1;
   localparam logic [2:0] ADDR_PULSE_MASK = 3'd2;
   localparam logic [2:0] ADDR_STATUS     = 3'd3;
   localparam logic [2:0] ADDR_OUTSET     = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

   // STATUS register bit positions
   localparam int STAT_BUSY = 0;
   localparam int STAT_OVR  = 1;

   // One-shot pulse engine states
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PULSING = 1'b1
   } pulse_state_e;

endpackage : max10nios_pio_pkg

// File: rtl/max10nios_pulse_timer.sv
// One-shot pulse timer: loads a length, counts it down once per clock and
// reports busy for exactly that many cycles. done flags the final busy cycle
// so the owner can retire the pulse on the same edge the timer goes idle.
module max10nios_pulse_timer
   import max10nios_pio_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done
);

   pulse_state_e     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;

   // Pulse FSM: a load in IDLE starts a pulse, the counter runs down to 1 and
   // the FSM returns to IDLE on that edge, so the counter never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load && (len != {CNT_W{1'b0}})) begin
                  r_state <= ST_PULSING;
                  r_cnt   <= len;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_cnt   <= r_cnt;
                  r_busy  <= 1'b0;
               end
            end
            ST_PULSING: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= {CNT_W{1'b0}};
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_PULSING;
                  r_cnt   <= r_cnt - CNT_W'(1);
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= {CNT_W{1'b0}};
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = (r_state == ST_PULSING) && (r_cnt == CNT_W'(1));

endmodule : max10nios_pulse_timer

// File: rtl/max10nios_pio_out_multi.sv
// WIDTH-bit Avalon-MM output PIO with atomic set/clear registers and a
// hardware one-shot pulse engine that inverts selected output bits for a
// programmable number of clocks. Reads are combinational, zero wait states.
module max10nios_pio_out_multi
   import max10nios_pio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             pulse_busy
);

   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_len;
   logic [WIDTH-1:0] r_mask;
   logic             r_ovr;

   logic             w_wr;
   logic             w_wr_data;
   logic             w_wr_len;
   logic             w_wr_mask;
   logic             w_wr_status;
   logic             w_wr_set;
   logic             w_wr_clr;
   logic [WIDTH-1:0] w_wd_port;
   logic [CNT_W-1:0] w_wd_len;
   logic             w_load;
   logic             w_busy;
   logic             w_done;
   logic             w_unused_ok;

   // Write strobe and per-register decodes
   assign w_wr        = chipselect & ~write_n;
   assign w_wr_data   = w_wr && (address == ADDR_DATA);
   assign w_wr_len    = w_wr && (address == ADDR_PULSE_LEN);
   assign w_wr_mask   = w_wr && (address == ADDR_PULSE_MASK);
   assign w_wr_status = w_wr && (address == ADDR_STATUS);
   assign w_wr_set    = w_wr && (address == ADDR_OUTSET);
   assign w_wr_clr    = w_wr && (address == ADDR_OUTCLEAR);

   // Registers keep only their own width of the bus; upper bits are dropped
   assign w_wd_port   = writedata[WIDTH-1:0];
   assign w_wd_len    = writedata[CNT_W-1:0];
   assign w_unused_ok = &{1'b0, writedata};

   // A trigger only starts a pulse from idle with a non-zero length and mask
   assign w_load = w_wr_mask && !w_busy
                   && (r_len != {CNT_W{1'b0}})
                   && (w_wd_port != {WIDTH{1'b0}});

   max10nios_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (w_load),
      .len   (r_len),
      .busy  (w_busy),
      .done  (w_done)
   );

   // DATA register: direct write, atomic OR-set and AND-NOT-clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= RESET_VALUE;
      end else if (w_wr_data) begin
         r_data <= w_wd_port;
      end else if (w_wr_set) begin
         r_data <= r_data | w_wd_port;
      end else if (w_wr_clr) begin
         r_data <= r_data & ~w_wd_port;
      end else begin
         r_data <= r_data;
      end
   end

   // PULSE_LEN register: a running pulse already holds its own copy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len <= {CNT_W{1'b0}};
      end else if (w_wr_len) begin
         r_len <= w_wd_len;
      end else begin
         r_len <= r_len;
      end
   end

   // Active mask latch: captured on trigger, cleared on the last pulse cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mask <= {WIDTH{1'b0}};
      end else if (w_load) begin
         r_mask <= w_wd_port;
      end else if (w_done) begin
         r_mask <= {WIDTH{1'b0}};
      end else begin
         r_mask <= r_mask;
      end
   end

   // Sticky overrun: a trigger during a pulse sets it, W1C clears it, set wins
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovr <= 1'b0;
      end else if (w_wr_mask && w_busy) begin
         r_ovr <= 1'b1;
      end else if (w_wr_status && writedata[STAT_OVR]) begin
         r_ovr <= 1'b0;
      end else begin
         r_ovr <= r_ovr;
      end
   end

   // Read mux: zero-extended registers, write-only and reserved words read 0
   always_comb begin
      readdata = 32'h0000_0000;
      case (address)
         ADDR_DATA: begin
            readdata[WIDTH-1:0] = r_data;
         end
         ADDR_PULSE_LEN: begin
            readdata[CNT_W-1:0] = r_len;
         end
         ADDR_PULSE_MASK: begin
            readdata[WIDTH-1:0] = r_mask;
         end
         ADDR_STATUS: begin
            readdata[STAT_BUSY] = w_busy;
            readdata[STAT_OVR]  = r_ovr;
         end
         default: begin
            readdata = 32'h0000_0000;
         end
      endcase
   end

   // Pulsed bits are inverted relative to whatever DATA currently holds
   assign out_port   = r_data ^ r_mask;
   assign pulse_busy = w_busy;

endmodule : max10nios_pio_out_multi

// File: tb/tb_max10nios_pio_out_multi.sv
// Scoreboard bench for max10nios_pio_out_multi (WIDTH=8, RESET_VALUE=8'hA5).
// The driver applies one bus cycle per clock, asks a cycle-count reference
// model what the DUT must show during that cycle and queues it; a monitor on
// the falling edge pops each entry and compares.
module tb_max10nios_pio_out_multi;
   import max10nios_pio_pkg::*;

   localparam int         W  = 8;
   localparam int         CW = 16;
   localparam logic [7:0] RV = 8'hA5;

   logic        clk;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;
   logic        pulse_busy;

   max10nios_pio_out_multi #(
      .WIDTH       (W),
      .RESET_VALUE (RV),
      .CNT_W       (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .pulse_busy (pulse_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  out;
      logic        busy;
      logic        chk_rd;
      logic [2:0]  addr;
      logic [31:0] rd;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: pulse tracked as "cycles still to go"
   logic [7:0] m_data;
   int         m_len;
   int         m_rem;
   logic [7:0] m_pmask;
   logic       m_ovr;

   // Monitor: compare what the DUT shows against the queued expectation
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_vec++;
         if (out_port !== e.out) begin
            n_err++;
            $display("FAIL out_port: got %h expected %h at %0t", out_port, e.out, $time);
         end
         n_vec++;
         if (pulse_busy !== e.busy) begin
            n_err++;
            $display("FAIL pulse_busy: got %b expected %b at %0t", pulse_busy, e.busy, $time);
         end
         if (e.chk_rd) begin
            n_vec++;
            if (readdata !== e.rd) begin
               n_err++;
               $display("FAIL readdata[%0d]: got %h expected %h at %0t", e.addr, readdata, e.rd, $time);
            end
         end
      end
   end

   // One clock of stimulus: queue this cycle's expectation, advance the model
   task automatic cycle(input logic rst, input logic cs, input logic wn,
                        input logic [2:0] a, input logic [31:0] wd);
      exp_t       e;
      logic       busy_now;
      logic       wr;
      logic       ovr_set;
      logic       ovr_clr;
      logic [7:0] wd8;
      reset      = rst;
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = wd;
      busy_now   = (m_rem > 0);
      wd8        = wd[7:0];
      e.out      = m_data ^ (busy_now ? m_pmask : 8'h00);
      e.busy     = busy_now;
      e.chk_rd   = cs && wn;
      e.addr     = a;
      case (a)
         3'd0:    e.rd = {24'h0, m_data};
         3'd1:    e.rd = m_len;
         3'd2:    e.rd = {24'h0, (busy_now ? m_pmask : 8'h00)};
         3'd3:    e.rd = {30'h0, m_ovr, busy_now};
         default: e.rd = 32'h0;
      endcase
      sb_q.push_back(e);
      if (rst) begin
         m_data = RV; m_len = 0; m_rem = 0; m_pmask = 8'h00; m_ovr = 1'b0;
      end else begin
         wr      = cs && !wn;
         ovr_set = 1'b0;
         ovr_clr = 1'b0;
         if (busy_now) m_rem = m_rem - 1;
         if (wr) begin
            case (a)
               3'd0: m_data = wd8;
               3'd1: m_len = int'(wd[15:0]);
               3'd2: begin
                  if (busy_now) ovr_set = 1'b1;
                  else if (m_len != 0 && wd8 != 8'h00) begin
                     m_rem   = m_len;
                     m_pmask = wd8;
                  end
               end
               3'd3: if (wd[1]) ovr_clr = 1'b1;
               3'd4: m_data = m_data | wd8;
               3'd5: m_data = m_data & ~wd8;
               default: ;
            endcase
         end
         if (ovr_set) m_ovr = 1'b1;
         else if (ovr_clr) m_ovr = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cycle(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [2:0] a);
      cycle(1'b0, 1'b1, 1'b1, a, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
   endtask

   initial begin
      int          wait_cnt;
      logic [2:0]  ra;
      logic [31:0] rwd;
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
      m_data = RV; m_len = 0; m_rem = 0; m_pmask = 8'h00; m_ovr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state and full read map
      for (int i = 0; i < 8; i++) rd(3'(i));

      // DATA, OUTSET, OUTCLEAR
      wr(ADDR_DATA, 32'h0F); wr(ADDR_OUTSET, 32'h30); wr(ADDR_OUTCLEAR, 32'h01);
      rd(ADDR_DATA);

      // 3-cycle pulse on 0x81
      wr(ADDR_PULSE_LEN, 32'd3); wr(ADDR_DATA, 32'h00); wr(ADDR_PULSE_MASK, 32'h81);
      rd(ADDR_PULSE_MASK); idle(4); rd(ADDR_PULSE_MASK);

      // Overrun during a 10-cycle pulse, then W1C
      wr(ADDR_PULSE_LEN, 32'd10); wr(ADDR_PULSE_MASK, 32'h01); idle(2);
      wr(ADDR_PULSE_MASK, 32'h02); rd(ADDR_STATUS); idle(7);
      rd(ADDR_STATUS); wr(ADDR_STATUS, 32'h2); rd(ADDR_STATUS);

      // DATA write mid-pulse keeps the bit inverted
      wr(ADDR_DATA, 32'h00); wr(ADDR_PULSE_MASK, 32'h01); idle(3);
      wr(ADDR_DATA, 32'h01); idle(8); rd(ADDR_DATA);

      // Reset mid-pulse with a coincident DATA write
      wr(ADDR_PULSE_LEN, 32'd5); wr(ADDR_PULSE_MASK, 32'h01); idle(1);
      cycle(1'b1, 1'b1, 1'b0, ADDR_DATA, 32'hFF);
      rd(ADDR_STATUS); rd(ADDR_DATA); rd(ADDR_PULSE_LEN);

      // Zero length trigger is ignored
      wr(ADDR_PULSE_LEN, 32'd0); wr(ADDR_PULSE_MASK, 32'hFF); rd(ADDR_STATUS); idle(1);

      // Zero mask trigger is ignored; upper writedata bits are dropped
      wr(ADDR_PULSE_LEN, 32'hABCD_0004); rd(ADDR_PULSE_LEN);
      wr(ADDR_PULSE_MASK, 32'hFFFF_FF00); rd(ADDR_STATUS);
      wr(ADDR_DATA, 32'hFFFF_FF5A); rd(ADDR_DATA);

      // Maximum length loads without wrapping; retrigger then reset
      wr(ADDR_PULSE_LEN, 32'h0000_FFFF); wr(ADDR_PULSE_MASK, 32'h10); idle(20);
      rd(ADDR_PULSE_LEN); wr(ADDR_PULSE_MASK, 32'h01); rd(ADDR_STATUS);
      cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
      rd(ADDR_STATUS);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         ra  = 3'($urandom_range(0, 7));
         rwd = $urandom;
         if (ra == ADDR_PULSE_LEN) rwd = {rwd[31:16], 16'($urandom_range(0, 9))};
         if ($urandom_range(0, 199) == 0)
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, ra, rwd);
         else if ($urandom_range(0, 3) == 0)
            idle(1);
         else
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), ra, rwd);
      end
      idle(12);

      wait_cnt = 0;
      while (sb_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (sb_q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_max10nios_pio_out_multi
